// File: rtl/sys_cmd_pkg.sv
// rtl/sys_cmd_pkg.sv - opcodes, controller states and response sizing for sys_cmd_ctrl
package sys_cmd_pkg;

  localparam logic [7:0] OP_WR  = 8'hAA;
  localparam logic [7:0] OP_RD  = 8'hBB;
  localparam logic [7:0] OP_ALU = 8'hCC;
  localparam logic [7:0] OP_NOP = 8'hDD;
  localparam logic [7:0] OP_BWR = 8'hEE;
  localparam logic [7:0] OP_BRD = 8'hEF;

  localparam logic [1:0] RESP_WORDS = 2'd2;

  typedef enum logic [3:0] {
    IDLE,
    RX_ADDR,
    RX_CNT,
    RX_DATA,
    RX_A,
    RX_B,
    RX_FUNC,
    RD_REQ,
    RD_WAIT,
    ALU_START,
    ALU_WAIT,
    PUSH
  } state_t;

endpackage

// File: rtl/sys_cmd_timeout.sv
// rtl/sys_cmd_timeout.sv - inter-byte frame timeout counter with clear/enable and expire pulse
module sys_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_expire = i_en && (r_count == LAST);

endmodule

// File: rtl/sys_cmd_ctrl.sv
// rtl/sys_cmd_ctrl.sv - byte-stream command decoder driving register file, ALU and TX FIFO
module sys_cmd_ctrl
  import sys_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_FUNC_WIDTH = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     RX_DATA_IN,
  input  logic                      RX_DATA_VALID,
  output logic [ADDR_WIDTH-1:0]     RegFile_ADDRESS,
  output logic                      RegFile_WrEn,
  output logic                      RegFile_RdEn,
  output logic [DATA_WIDTH-1:0]     RegFile_WrData,
  input  logic [DATA_WIDTH-1:0]     RegFile_RdData,
  input  logic                      RegFile_DATA_VAILD,
  output logic [ALU_FUNC_WIDTH-1:0] ALU_FUNC,
  output logic                      ALU_EN,
  output logic                      ALU_CLK_EN,
  input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
  input  logic                      ALU_DATA_VALID,
  output logic                      FIFO_WR,
  input  logic                      FIFO_FULL,
  output logic [DATA_WIDTH-1:0]     TX_DATA_OUT,
  output logic                      FRAME_ERR,
  output logic                      RX_OVERRUN
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [DATA_WIDTH-1:0] CNT_ONE  = 1;

  state_t                    r_state, w_state_nxt;
  logic [7:0]                r_op, w_op_nxt;
  logic [ADDR_WIDTH-1:0]     r_ptr, w_ptr_nxt;
  logic [DATA_WIDTH-1:0]     r_cnt, w_cnt_nxt;
  logic [1:0]                r_words, w_words_nxt;
  logic [2*DATA_WIDTH-1:0]   r_resp, w_resp_nxt;
  logic [ADDR_WIDTH-1:0]     r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0]     r_wr_data, w_wr_data_nxt;
  logic [ALU_FUNC_WIDTH-1:0] r_alu_func, w_alu_func_nxt;
  logic                      r_wr_en, w_wr_en_nxt;
  logic                      r_rd_en, w_rd_en_nxt;
  logic                      r_alu_en, w_alu_en_nxt;
  logic                      r_clk_en, w_clk_en_nxt;
  logic                      r_ferr, w_ferr_nxt;

  logic       w_tmo_en, w_rx_state, w_take, w_expire;
  logic [7:0] w_byte;

  assign w_byte     = RX_DATA_IN[7:0];
  assign w_tmo_en   = (r_state == RX_ADDR) || (r_state == RX_CNT) || (r_state == RX_DATA) ||
                      (r_state == RX_A) || (r_state == RX_B) || (r_state == RX_FUNC);
  assign w_rx_state = (r_state == IDLE) || w_tmo_en;
  // An expiring timeout swallows a byte landing in the same cycle.
  assign w_take     = RX_DATA_VALID && w_rx_state && !w_expire;

  sys_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_clear  (w_take || !w_tmo_en),
    .i_en     (w_tmo_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_words    <= '0;
      r_resp     <= '0;
      r_addr     <= '0;
      r_wr_data  <= '0;
      r_alu_func <= '0;
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_alu_en   <= 1'b0;
      r_clk_en   <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_words    <= w_words_nxt;
      r_resp     <= w_resp_nxt;
      r_addr     <= w_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_alu_func <= w_alu_func_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_rd_en    <= w_rd_en_nxt;
      r_alu_en   <= w_alu_en_nxt;
      r_clk_en   <= w_clk_en_nxt;
      r_ferr     <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_ptr_nxt      = r_ptr;
    w_cnt_nxt      = r_cnt;
    w_words_nxt    = r_words;
    w_resp_nxt     = r_resp;
    w_addr_nxt     = r_addr;
    w_wr_data_nxt  = r_wr_data;
    w_alu_func_nxt = r_alu_func;
    w_clk_en_nxt   = r_clk_en;
    w_wr_en_nxt    = 1'b0;
    w_rd_en_nxt    = 1'b0;
    w_alu_en_nxt   = 1'b0;
    w_ferr_nxt     = 1'b0;
    if (w_expire) begin
      w_state_nxt = IDLE;
      w_ferr_nxt  = 1'b1;
    end else begin
      case (r_state)
        IDLE: if (w_take) begin
          w_op_nxt = w_byte;
          case (w_byte)
            OP_WR, OP_RD, OP_BWR, OP_BRD: w_state_nxt = RX_ADDR;
            OP_ALU:                       w_state_nxt = RX_A;
            OP_NOP:                       w_state_nxt = RX_FUNC;
            default:                      w_ferr_nxt  = 1'b1;
          endcase
        end
        RX_ADDR: if (w_take) begin
          // Single WR/RD reuse the burst path with a count of one.
          w_ptr_nxt = RX_DATA_IN[ADDR_WIDTH-1:0];
          w_cnt_nxt = CNT_ONE;
          if (r_op == OP_WR)      w_state_nxt = RX_DATA;
          else if (r_op == OP_RD) w_state_nxt = RD_REQ;
          else                    w_state_nxt = RX_CNT;
        end
        RX_CNT: if (w_take) begin
          w_cnt_nxt = RX_DATA_IN;
          if (RX_DATA_IN == '0)    w_state_nxt = IDLE;
          else if (r_op == OP_BWR) w_state_nxt = RX_DATA;
          else                     w_state_nxt = RD_REQ;
        end
        RX_DATA: if (w_take) begin
          w_wr_en_nxt   = 1'b1;
          w_addr_nxt    = r_ptr;
          w_wr_data_nxt = RX_DATA_IN;
          w_ptr_nxt     = r_ptr + ADDR_ONE;
          w_cnt_nxt     = r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) w_state_nxt = IDLE;
        end
        RX_A: if (w_take) begin
          w_wr_en_nxt   = 1'b1;
          w_addr_nxt    = '0;
          w_wr_data_nxt = RX_DATA_IN;
          w_state_nxt   = RX_B;
        end
        RX_B: if (w_take) begin
          w_wr_en_nxt   = 1'b1;
          w_addr_nxt    = ADDR_ONE;
          w_wr_data_nxt = RX_DATA_IN;
          w_state_nxt   = RX_FUNC;
        end
        RX_FUNC: if (w_take) begin
          w_alu_func_nxt = RX_DATA_IN[ALU_FUNC_WIDTH-1:0];
          w_clk_en_nxt   = 1'b1;
          w_state_nxt    = ALU_START;
        end
        ALU_START: begin
          w_alu_en_nxt = 1'b1;
          w_state_nxt  = ALU_WAIT;
        end
        ALU_WAIT: if (ALU_DATA_VALID) begin
          w_resp_nxt  = ALU_OUT;
          w_words_nxt = RESP_WORDS;
          w_state_nxt = PUSH;
        end
        RD_REQ: begin
          w_rd_en_nxt = 1'b1;
          w_addr_nxt  = r_ptr;
          w_state_nxt = RD_WAIT;
        end
        RD_WAIT: if (RegFile_DATA_VAILD) begin
          w_resp_nxt  = {{DATA_WIDTH{1'b0}}, RegFile_RdData};
          w_words_nxt = 2'd1;
          w_ptr_nxt   = r_ptr + ADDR_ONE;
          w_cnt_nxt   = r_cnt - CNT_ONE;
          w_state_nxt = PUSH;
        end
        PUSH: if (!FIFO_FULL) begin
          w_resp_nxt  = r_resp >> DATA_WIDTH;
          w_words_nxt = r_words - 2'd1;
          if (r_words == 2'd1) begin
            if ((r_op == OP_ALU) || (r_op == OP_NOP)) begin
              w_clk_en_nxt = 1'b0;
              w_state_nxt  = IDLE;
            end else if (r_cnt != '0) begin
              w_state_nxt = RD_REQ;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign RegFile_ADDRESS = r_addr;
  assign RegFile_WrEn    = r_wr_en;
  assign RegFile_RdEn    = r_rd_en;
  assign RegFile_WrData  = r_wr_data;
  assign ALU_FUNC        = r_alu_func;
  assign ALU_EN          = r_alu_en;
  assign ALU_CLK_EN      = r_clk_en;
  assign FIFO_WR         = (r_state == PUSH) && !FIFO_FULL;
  assign TX_DATA_OUT     = r_resp[DATA_WIDTH-1:0];
  assign FRAME_ERR       = r_ferr;
  assign RX_OVERRUN      = RX_DATA_VALID && !w_rx_state;

endmodule
